// File: rtl/rapid_pkg.sv
// rapid_pkg: definitions shared by the memory stage and its byte-lane helper.
// Contents: datapath width, load/store width codes (fcs), the memory-stage
// FSM state type and the decoded control word forwarded down the pipeline.
package rapid_pkg;

    localparam int XLEN = 32;

    // Load/store width codes carried in control_s.fcs
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_RESP   = 2'd2
    } MEM_state_t;

    // mem: memory instruction; iop: 0 load / 1 store; fcs: width code
    typedef struct packed {
        logic       mem;
        logic       iop;
        logic [2:0] fcs;
        logic       reg_write;
        logic [4:0] rd;
    } control_s;

    function automatic control_s control_s_default();
        control_s c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit data bus.
// Ports:
//   i_fcs        width code (LS_B/H/W/BU/HU)
//   i_addr       low two bits of the byte address
//   i_rs2        store data
//   i_rdata      read word from the bus
//   o_wdata      lane-replicated store data
//   o_wstrb      byte enables for a store
//   o_load       selected and sign/zero-extended load result
//   o_misaligned illegal width code or address not aligned to the width
module mem_lane_align
    import rapid_pkg::*;
(
    input  logic [2:0]      i_fcs,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_wdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_load,
    output logic            o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_addr +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wdata      = '0;
        o_wstrb      = '0;
        o_load       = '0;
        o_misaligned = 1'b0;
        case (i_fcs)
            LS_B, LS_BU: begin
                o_wdata = {4{i_rs2[7:0]}};
                o_wstrb = 4'b0001 << i_addr;
                o_load  = (i_fcs == LS_B) ? {{(XLEN-8){w_byte[7]}}, w_byte}
                                          : {{(XLEN-8){1'b0}}, w_byte};
            end
            LS_H, LS_HU: begin
                o_wdata      = {2{i_rs2[15:0]}};
                o_wstrb      = i_addr[1] ? 4'b1100 : 4'b0011;
                o_load       = (i_fcs == LS_H) ? {{(XLEN-16){w_half[15]}}, w_half}
                                               : {{(XLEN-16){1'b0}}, w_half};
                o_misaligned = i_addr[0];
            end
            LS_W: begin
                o_wdata      = i_rs2;
                o_wstrb      = 4'b1111;
                o_load       = i_rdata;
                o_misaligned = (i_addr != 2'b00);
            end
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Runs one load/store per memory
// instruction on a single-outstanding req/ack bus; other instructions pass
// straight through to writeback. Holds one instruction at a time.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that gets no
// ack within TIMEOUT_CYCLES request cycles (result reported as a fault).
// Ports:
//   i_clk, i_reset_n                     clock, async active-low reset
//   i_ex_valid/o_ex_ready                EX handshake
//   i_control_signal, i_rd_output, i_rs2 instruction from EX
//   o_mem_req/we/addr/wdata/wstrb        bus request
//   i_mem_ack, i_mem_rdata               bus response
//   o_wb_valid/i_wb_ready                WB handshake
//   o_control_signal, o_rd_data, o_fault result to WB
module mem_stage
    import rapid_pkg::*;
#(
    parameter int ADDR_W         = XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  control_s          i_control_signal,
    input  logic [XLEN-1:0]   i_rd_output,
    input  logic [XLEN-1:0]   i_rs2,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output control_s          o_control_signal,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_fault
);

    MEM_state_t      r_state, w_next;
    control_s        r_ctrl;
    logic [XLEN-1:0] r_addr, r_rs2, r_rd_data;
    logic            r_fault;

    logic            w_accept, w_illegal, w_go_access, w_timeout;
    logic [2:0]      w_al_fcs;
    logic [1:0]      w_al_addr;
    logic [XLEN-1:0] w_wdata, w_load;
    logic [3:0]      w_wstrb;
    logic            w_misaligned;

    // The aligner sees the incoming instruction while idle (legality check at
    // accept) and the latched one otherwise (bus drive and load capture).
    assign w_al_fcs  = (r_state == MEM_IDLE) ? i_control_signal.fcs : r_ctrl.fcs;
    assign w_al_addr = (r_state == MEM_IDLE) ? i_rd_output[1:0]     : r_addr[1:0];

    mem_lane_align u_align (
        .i_fcs        (w_al_fcs),
        .i_addr       (w_al_addr),
        .i_rs2        (r_rs2),
        .i_rdata      (i_mem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load       (w_load),
        .o_misaligned (w_misaligned)
    );

    // Unsigned widths (fcs[2]=1) are load-only.
    assign w_illegal   = w_misaligned | (i_control_signal.iop & i_control_signal.fcs[2]);
    assign w_go_access = i_control_signal.mem & ~w_illegal;
    assign w_accept    = i_ex_valid & o_ex_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_to_cnt <= '0;
        else if (r_state != MEM_ACCESS)
            r_to_cnt <= '0;
        else if (!i_mem_ack)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_state == MEM_ACCESS) && !i_mem_ack &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= MEM_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            MEM_IDLE:   if (w_accept) w_next = w_go_access ? MEM_ACCESS : MEM_RESP;
            MEM_ACCESS: if (i_mem_ack || w_timeout) w_next = MEM_RESP;
            MEM_RESP:   if (i_wb_ready) w_next = MEM_IDLE;
            default:    w_next = MEM_IDLE;
        endcase
    end

    // Instruction and result registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ctrl    <= control_s_default();
            r_addr    <= '0;
            r_rs2     <= '0;
            r_rd_data <= '0;
            r_fault   <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= i_control_signal;
            r_addr    <= i_rd_output;
            r_rs2     <= i_rs2;
            r_rd_data <= i_control_signal.mem ? '0 : i_rd_output;
            r_fault   <= i_control_signal.mem & w_illegal;
        end else if (r_state == MEM_ACCESS) begin
            if (i_mem_ack) begin
                r_rd_data <= r_ctrl.iop ? '0 : w_load;
            end else if (w_timeout) begin
                r_rd_data <= '0;
                r_fault   <= 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        o_ex_ready       = (r_state == MEM_IDLE) & i_reset_n;
        o_mem_req        = (r_state == MEM_ACCESS);
        o_mem_we         = o_mem_req & r_ctrl.iop;
        o_mem_addr       = o_mem_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
        o_mem_wdata      = o_mem_we ? w_wdata : '0;
        o_mem_wstrb      = o_mem_we ? w_wstrb : '0;
        o_wb_valid       = (r_state == MEM_RESP);
        o_control_signal = r_ctrl;
        o_rd_data        = o_wb_valid ? r_rd_data : '0;
        o_fault          = o_wb_valid & r_fault;
    end

endmodule
